// File: rtl/dff_shift_bank.sv
// dff_shift_bank: WIDTH-bit universal register (hold / load / shift left /
// shift right) with serial in/out at both ends, plus a shift counter that
// pulses 'wrap' each time a full word has been shifted through.
// Optional build macro DSB_ROTATE_EN: when defined, shifts issued with rot=1
// recirculate the outgoing bit instead of taking sin_l/sin_r. The port list
// is the same in both builds; without the macro 'rot' is ignored.
module dff_shift_bank #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_t;

  mode_t            w_mode;
  logic             w_sinL;
  logic             w_sinR;
  logic [WIDTH-1:0] w_shlQ;
  logic [WIDTH-1:0] w_shrQ;
  logic             w_cntAtLast;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_shiftCnt;
  logic             r_wrap;

  assign w_mode      = mode_t'(mode);
  assign w_cntAtLast = (r_shiftCnt == CW'(WIDTH - 1));

`ifdef DSB_ROTATE_EN
  // Rotation feeds the bit falling off one end back into the other end.
  always_comb begin
    w_sinL = rot ? r_q[WIDTH-1] : sin_l;
    w_sinR = rot ? r_q[0]       : sin_r;
  end
`else
  logic w_rotUnused;
  assign w_rotUnused = rot;

  // Without rotation support the serial inputs always come from the pins.
  always_comb begin
    w_sinL = sin_l;
    w_sinR = sin_r;
  end
`endif

  // Shifted candidates; written with shifts so WIDTH=1 simply loads the serial bit.
  always_comb begin
    w_shlQ    = r_q << 1;
    w_shlQ[0] = w_sinL;
    w_shrQ          = r_q >> 1;
    w_shrQ[WIDTH-1] = w_sinR;
  end

  // Register contents, shift counter and wrap pulse; reset dominates enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q        <= RESET_VAL;
      r_shiftCnt <= '0;
      r_wrap     <= 1'b0;
    end else if (!en) begin
      r_wrap <= 1'b0;
    end else begin
      case (w_mode)
        MODE_HOLD: begin
          r_wrap <= 1'b0;
        end
        MODE_LOAD: begin
          r_q        <= d;
          r_shiftCnt <= '0;
          r_wrap     <= 1'b0;
        end
        MODE_SHL, MODE_SHR: begin
          r_q <= (w_mode == MODE_SHL) ? w_shlQ : w_shrQ;
          if (w_cntAtLast) begin
            r_shiftCnt <= '0;
            r_wrap     <= 1'b1;
          end else begin
            r_shiftCnt <= r_shiftCnt + 1'b1;
            r_wrap     <= 1'b0;
          end
        end
        default: begin
          r_wrap <= 1'b0;
        end
      endcase
    end
  end

  assign q         = r_q;
  assign qn        = ~r_q;
  assign sout_l    = r_q[WIDTH-1];
  assign sout_r    = r_q[0];
  assign shift_cnt = r_shiftCnt;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_dff_shift_bank.sv
// tb_dff_shift_bank: directed scenarios plus randomized traffic for
// dff_shift_bank (WIDTH=4, RESET_VAL=0), compared against a word-level
// reference model that counts shifts since the last load.
module tb_dff_shift_bank;

  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int MASK = (1 << W) - 1;

  logic          clk;
  logic          reset;
  logic          en;
  logic [1:0]    mode;
  logic [W-1:0]  d;
  logic          sinL;
  logic          sinR;
  logic          rot;
  logic [W-1:0]  q;
  logic [W-1:0]  qn;
  logic          soutL;
  logic          soutR;
  logic [CW-1:0] shiftCnt;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  int mQ;
  int mShifts;
  int mWrap;

  dff_shift_bank #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_l    (sinL),
    .sin_r    (sinR),
    .rot      (rot),
    .q        (q),
    .qn       (qn),
    .sout_l   (soutL),
    .sout_r   (soutR),
    .shift_cnt(shiftCnt),
    .wrap     (wrap)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference model.
  task automatic checkModel(input string tag);
    checkOutput({tag, "_q"},    32'(q),        32'(mQ));
    checkOutput({tag, "_qn"},   32'(qn),       32'((~mQ) & MASK));
    checkOutput({tag, "_soL"},  32'(soutL),    32'((mQ >> (W - 1)) & 1));
    checkOutput({tag, "_soR"},  32'(soutR),    32'(mQ & 1));
    checkOutput({tag, "_cnt"},  32'(shiftCnt), 32'(mShifts % W));
    checkOutput({tag, "_wrap"}, 32'(wrap),     32'(mWrap));
  endtask

  // Reference behaviour of one enabled/disabled clock edge at word level.
  task automatic modelEdge(input logic e, input logic [1:0] md, input logic [W-1:0] dv,
                           input logic sl, input logic sr, input logic rt);
    int bitL;
    int bitR;
    bitL = sl;
    bitR = sr;
`ifdef DSB_ROTATE_EN
    if (rt) begin
      bitL = (mQ >> (W - 1)) & 1;
      bitR = mQ & 1;
    end
`else
    if (rt) begin
      bitL = sl;
    end
`endif
    mWrap = 0;
    if (e) begin
      if (md == 2'b01) begin
        mQ      = dv;
        mShifts = 0;
      end else if (md == 2'b10 || md == 2'b11) begin
        if (md == 2'b10) mQ = ((mQ * 2) + bitL) & MASK;
        else             mQ = (mQ / 2) + (bitR << (W - 1));
        mShifts = mShifts + 1;
        if (mShifts % W == 0) begin
          mWrap   = 1;
          mShifts = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check just after the rising edge.
  task automatic applyStimulus(input logic e, input logic [1:0] md, input logic [W-1:0] dv,
                               input logic sl, input logic sr, input logic rt, input string tag);
    @(negedge clk);
    en   = e;
    mode = md;
    d    = dv;
    sinL = sl;
    sinR = sr;
    rot  = rt;
    @(posedge clk);
    modelEdge(e, md, dv, sl, sr, rt);
    #1;
    checkModel(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic midCycleReset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    mQ      = 0;
    mShifts = 0;
    mWrap   = 0;
    checkOutput({tag, "_rq"},    32'(q),        32'h0);
    checkOutput({tag, "_rqn"},   32'(qn),       32'hF);
    checkOutput({tag, "_rcnt"},  32'(shiftCnt), 32'h0);
    checkOutput({tag, "_rwrap"}, 32'(wrap),     32'h0);
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    d     = '0;
    sinL  = 1'b0;
    sinR  = 1'b0;
    rot   = 1'b0;
    mQ      = 0;
    mShifts = 0;
    mWrap   = 0;
    #12;
    checkModel("por");
    @(negedge clk);
    reset = 1'b1;

    // Async reset mid-cycle while holding 0xA.
    applyStimulus(1, 2'b01, 4'hA, 0, 0, 0, "ldA");
    checkOutput("ldA_const", 32'(q), 32'hA);
    midCycleReset("rst");

    // Load all ones, then hold for three cycles.
    applyStimulus(1, 2'b01, 4'hF, 0, 0, 0, "ldF");
    checkOutput("ldF_qn_const", 32'(qn), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'b00, 4'h0, 1, 1, 0, "hold");
    checkOutput("hold_const", 32'(q), 32'hF);

    // Four left shifts of 1001 with sin_l=0: wrap only after the fourth.
    applyStimulus(1, 2'b01, 4'b1001, 0, 0, 0, "ld9");
    for (int i = 0; i < 4; i++) applyStimulus(1, 2'b10, 4'h0, 0, 1, 0, "shl");
    checkOutput("shl_q_const",    32'(q),    32'h0);
    checkOutput("shl_wrap_const", 32'(wrap), 32'h1);
    applyStimulus(1, 2'b00, 4'h0, 0, 0, 0, "shl_after");
    checkOutput("wrap_clear_const", 32'(wrap), 32'h0);

    // Shift right with enable toggling 1,0,1.
    applyStimulus(1, 2'b01, 4'b0001, 0, 0, 0, "ld1");
    applyStimulus(1, 2'b11, 4'h0, 0, 1, 0, "shr_e1");
    applyStimulus(0, 2'b11, 4'h0, 0, 1, 0, "shr_e0");
    applyStimulus(1, 2'b11, 4'h0, 0, 1, 0, "shr_e1b");
    checkOutput("shr_q_const",   32'(q),        32'hC);
    checkOutput("shr_cnt_const", 32'(shiftCnt), 32'h2);

    // Load in the middle of a count restarts it; four more shifts to wrap.
    applyStimulus(1, 2'b01, 4'h5, 0, 0, 0, "ld5");
    checkOutput("ld5_cnt_const", 32'(shiftCnt), 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1, (i % 2 == 0) ? 2'b10 : 2'b11, 4'h0, 1, 0, 0, "mix");
    checkOutput("mix_wrap_const", 32'(wrap), 32'h1);

    // Rotate request on a left shift of 1000.
    applyStimulus(1, 2'b01, 4'b1000, 0, 0, 0, "ld8");
    applyStimulus(1, 2'b10, 4'h0, 0, 0, 1, "rot");
`ifdef DSB_ROTATE_EN
    checkOutput("rot_const", 32'(q), 32'h1);
`else
    checkOutput("rot_const", 32'(q), 32'h0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        midCycleReset("rnd");
      end else begin
        applyStimulus(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
